// File: rtl/epb_opb_master_bridge_if.sv
// OPB master-side signal bundle for the EPB-to-OPB bridge.
// The bridge connects through the master modport; an OPB slave or arbiter
// model connects through the slave modport.
interface epb_opb_master_bridge_if;
  logic        M_request;
  logic        M_busLock;
  logic        M_select;
  logic        M_RNW;
  logic        M_seqAddr;
  logic [3:0]  M_BE;
  logic [31:0] M_DBus;
  logic [31:0] M_ABus;
  logic        OPB_MGrant;
  logic        OPB_xferAck;
  logic        OPB_errAck;
  logic        OPB_retry;
  logic        OPB_timeout;
  logic [31:0] OPB_DBus;

  modport master (
    output M_request, M_busLock, M_select, M_RNW, M_seqAddr, M_BE, M_DBus, M_ABus,
    input  OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout, OPB_DBus
  );

  modport slave (
    input  M_request, M_busLock, M_select, M_RNW, M_seqAddr, M_BE, M_DBus, M_ABus,
    output OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout, OPB_DBus
  );
endinterface

// File: rtl/epb_opb_master_bridge.sv
// EPB slave to OPB master bridge. Each EPB chip-select cycle becomes exactly
// one OPB master transfer, with bounded retry, a transfer watchdog and a
// sticky error register readable by software. Everything runs on OPB_Clk.
module epb_opb_master_bridge #(
  parameter int          EPB_AW      = 25,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          TOUT_CYCLES = 64,
  parameter int          MAX_RETRY   = 4
) (
  input  logic                  OPB_Clk,
  input  logic                  OPB_Rst,
  input  logic                  epb_cs_n,
  input  logic                  epb_oe_n,
  input  logic                  epb_r_w_n,
  input  logic [3:0]            epb_be_n,
  input  logic [EPB_AW-1:0]     epb_addr,
  input  logic [31:0]           epb_data_i,
  output logic [31:0]           epb_data_o,
  output logic                  epb_data_oe_n,
  output logic                  epb_rdy,
  epb_opb_master_bridge_if.master opb,
  input  logic                  err_clr,
  output logic                  err_flag,
  output logic [1:0]            err_code
);

  typedef enum logic [2:0] {IDLE, REQ, XFER, DONE, HOLD} state_e;

  state_e              state_q;
  logic                cs_n_dly_q;
  logic [EPB_AW-1:0]   addr_q;
  logic                rnw_q;
  logic [3:0]          be_n_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic [3:0]          retry_q;
  logic [3:0]          retry_d;
  logic [7:0]          wd_q;
  logic                req_q;
  logic                sel_q;
  logic                m_rnw_q;
  logic [3:0]          m_be_q;
  logic [31:0]         m_dbus_q;
  logic [31:0]         m_abus_q;
  logic                rdy_q;
  logic                err_flag_q;
  logic [1:0]          err_code_q;
  logic [1:0]          err_code_d;
  logic                err_set;
  logic                wd_hit;
  logic                xfer_exit;
  logic [31:0]         addr_ext;

  assign addr_ext = 32'({addr_q, 2'b00});

  // Classify the response seen in XFER: which error (if any) ends the transfer.
  always_comb begin
    retry_d    = retry_q + 4'd1;
    wd_hit     = (wd_q == 8'(TOUT_CYCLES - 1));
    xfer_exit  = opb.OPB_xferAck | opb.OPB_errAck | opb.OPB_timeout | opb.OPB_retry | wd_hit;
    err_set    = 1'b0;
    err_code_d = err_code_q;
    if (state_q == XFER && !opb.OPB_xferAck) begin
      if (opb.OPB_errAck) begin
        err_set    = 1'b1;
        err_code_d = 2'b01;
      end else if (opb.OPB_timeout || wd_hit) begin
        err_set    = 1'b1;
        err_code_d = 2'b10;
      end else if (opb.OPB_retry && retry_d == 4'(MAX_RETRY)) begin
        err_set    = 1'b1;
        err_code_d = 2'b11;
      end
    end
  end

  // Sticky error register: a new error beats a simultaneous clear.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      err_flag_q <= 1'b0;
      err_code_q <= 2'b00;
    end else if (err_set) begin
      err_flag_q <= 1'b1;
      err_code_q <= err_code_d;
    end else if (err_clr) begin
      err_flag_q <= 1'b0;
      err_code_q <= 2'b00;
    end
  end

  // Transfer sequencer with registered OPB/EPB outputs.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q    <= IDLE;
      cs_n_dly_q <= 1'b0;
      addr_q     <= '0;
      rnw_q      <= 1'b0;
      be_n_q     <= 4'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      retry_q    <= 4'h0;
      wd_q       <= 8'h0;
      req_q      <= 1'b0;
      sel_q      <= 1'b0;
      m_rnw_q    <= 1'b0;
      m_be_q     <= 4'h0;
      m_dbus_q   <= 32'h0;
      m_abus_q   <= 32'h0;
      rdy_q      <= 1'b0;
    end else begin
      cs_n_dly_q <= epb_cs_n;
      rdy_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cs_n_dly_q && !epb_cs_n) begin
            addr_q  <= epb_addr;
            rnw_q   <= epb_r_w_n;
            be_n_q  <= epb_be_n;
            wdata_q <= epb_data_i;
            retry_q <= 4'h0;
            wd_q    <= 8'h0;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (opb.OPB_MGrant) begin
            req_q    <= 1'b0;
            sel_q    <= 1'b1;
            m_rnw_q  <= rnw_q;
            m_abus_q <= ADDR_BASE | addr_ext;
            m_be_q   <= {~be_n_q[0], ~be_n_q[1], ~be_n_q[2], ~be_n_q[3]};
            m_dbus_q <= rnw_q ? 32'h0 : wdata_q;
            state_q  <= XFER;
          end
        end
        XFER: begin
          wd_q <= wd_q + 8'd1;
          if (xfer_exit) begin
            sel_q    <= 1'b0;
            m_rnw_q  <= 1'b0;
            m_abus_q <= 32'h0;
            m_be_q   <= 4'h0;
            m_dbus_q <= 32'h0;
          end
          // Failed reads return all-ones; writes leave the last read data intact.
          if (opb.OPB_xferAck) begin
            if (rnw_q) rdata_q <= opb.OPB_DBus;
            rdy_q   <= 1'b1;
            state_q <= DONE;
          end else if (opb.OPB_errAck || opb.OPB_timeout || wd_hit) begin
            if (rnw_q) rdata_q <= 32'hFFFF_FFFF;
            rdy_q   <= 1'b1;
            state_q <= DONE;
          end else if (opb.OPB_retry) begin
            retry_q <= retry_d;
            wd_q    <= 8'h0;
            if (retry_d == 4'(MAX_RETRY)) begin
              if (rnw_q) rdata_q <= 32'hFFFF_FFFF;
              rdy_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              req_q   <= 1'b1;
              state_q <= REQ;
            end
          end
        end
        DONE: begin
          state_q <= HOLD;
        end
        HOLD: begin
          if (epb_cs_n) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign opb.M_request = req_q;
  assign opb.M_busLock = 1'b0;
  assign opb.M_select  = sel_q;
  assign opb.M_RNW     = m_rnw_q;
  assign opb.M_seqAddr = 1'b0;
  assign opb.M_BE      = m_be_q;
  assign opb.M_DBus    = m_dbus_q;
  assign opb.M_ABus    = m_abus_q;

  assign epb_data_o    = rdata_q;
  assign epb_rdy       = rdy_q;
  assign err_flag      = err_flag_q;
  assign err_code      = err_code_q;
  assign epb_data_oe_n = ~((state_q == DONE || state_q == HOLD) && rnw_q && !epb_cs_n && !epb_oe_n);

endmodule

// File: tb/tb_epb_opb_master_bridge.sv
// Directed self-checking bench for the EPB-to-OPB bridge. Each task drives
// one scenario and compares outputs against hand-computed values.
module tb_epb_opb_master_bridge;
  localparam int          EPB_AW    = 25;
  localparam logic [31:0] ADDR_BASE = 32'h8000_0000;
  localparam int          TOUT      = 64;
  localparam int          MAXR      = 4;

  logic              OPB_Clk = 1'b0;
  logic              OPB_Rst = 1'b1;
  logic              epb_cs_n = 1'b1;
  logic              epb_oe_n = 1'b1;
  logic              epb_r_w_n = 1'b1;
  logic [3:0]        epb_be_n = 4'hF;
  logic [EPB_AW-1:0] epb_addr = '0;
  logic [31:0]       epb_data_i = 32'h0;
  logic [31:0]       epb_data_o;
  logic              epb_data_oe_n;
  logic              epb_rdy;
  logic              err_clr = 1'b0;
  logic              err_flag;
  logic [1:0]        err_code;

  int vectors = 0;
  int miscompares = 0;

  epb_opb_master_bridge_if bus ();

  epb_opb_master_bridge #(
    .EPB_AW(EPB_AW), .ADDR_BASE(ADDR_BASE), .TOUT_CYCLES(TOUT), .MAX_RETRY(MAXR)
  ) dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst),
    .epb_cs_n(epb_cs_n), .epb_oe_n(epb_oe_n), .epb_r_w_n(epb_r_w_n),
    .epb_be_n(epb_be_n), .epb_addr(epb_addr), .epb_data_i(epb_data_i),
    .epb_data_o(epb_data_o), .epb_data_oe_n(epb_data_oe_n), .epb_rdy(epb_rdy),
    .opb(bus.master),
    .err_clr(err_clr), .err_flag(err_flag), .err_code(err_code)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  task automatic tick();
    @(posedge OPB_Clk);
    #1;
  endtask

  task automatic idleBus();
    bus.OPB_MGrant  = 1'b0;
    bus.OPB_xferAck = 1'b0;
    bus.OPB_errAck  = 1'b0;
    bus.OPB_retry   = 1'b0;
    bus.OPB_timeout = 1'b0;
    err_clr         = 1'b0;
  endtask

  task automatic startXfer(input logic rnw, input logic [EPB_AW-1:0] a,
                           input logic [3:0] be, input logic [31:0] d);
    epb_r_w_n  = rnw;
    epb_addr   = a;
    epb_be_n   = be;
    epb_data_i = d;
    epb_oe_n   = 1'b0;
    epb_cs_n   = 1'b0;
  endtask

  task automatic endXfer();
    epb_cs_n = 1'b1;
    epb_oe_n = 1'b1;
    idleBus();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    idleBus();
    bus.OPB_DBus = 32'h0;
    OPB_Rst = 1'b1;
    tick();
    tick();
    vectors++;
    if ({bus.M_request, bus.M_select, bus.M_RNW, bus.M_busLock, bus.M_seqAddr, epb_rdy, epb_data_oe_n, err_flag} !== 8'b0000_0010) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b expected %b", {bus.M_request, bus.M_select, bus.M_RNW, bus.M_busLock, bus.M_seqAddr, epb_rdy, epb_data_oe_n, err_flag}, 8'b0000_0010);
    end
    vectors++;
    if ({bus.M_ABus, bus.M_DBus, bus.M_BE, err_code} !== 70'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_bus: got %h/%h/%h/%b expected all zero", bus.M_ABus, bus.M_DBus, bus.M_BE, err_code);
    end
    vectors++;
    if (epb_data_o !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_data_o: got %h expected %h", epb_data_o, 32'h0);
    end
    OPB_Rst = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_write();
    startXfer(1'b0, 25'h10, 4'b0000, 32'hA5A5_1234);
    bus.OPB_MGrant  = 1'b1;
    bus.OPB_xferAck = 1'b1;
    tick();
    vectors++;
    if ({bus.M_request, bus.M_select} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL wr_req_edge0: got %b expected %b", {bus.M_request, bus.M_select}, 2'b10);
    end
    tick();
    vectors++;
    if ({bus.M_request, bus.M_select, bus.M_RNW, epb_rdy} !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL wr_sel_edge1: got %b expected %b", {bus.M_request, bus.M_select, bus.M_RNW, epb_rdy}, 4'b0100);
    end
    vectors++;
    if ({bus.M_ABus, bus.M_BE, bus.M_DBus} !== {ADDR_BASE | 32'h40, 4'hF, 32'hA5A5_1234}) begin
      miscompares++;
      $display("[TB] FAIL wr_bus: got %h/%h/%h expected %h/%h/%h", bus.M_ABus, bus.M_BE, bus.M_DBus, ADDR_BASE | 32'h40, 4'hF, 32'hA5A5_1234);
    end
    tick();
    vectors++;
    if ({bus.M_select, epb_rdy, bus.M_ABus} !== {2'b01, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL wr_rdy_edge2: got sel=%b rdy=%b abus=%h expected sel=0 rdy=1 abus=0", bus.M_select, epb_rdy, bus.M_ABus);
    end
    tick();
    vectors++;
    if ({epb_rdy, epb_data_oe_n, err_flag} !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL wr_after: got %b expected %b", {epb_rdy, epb_data_oe_n, err_flag}, 3'b010);
    end
    endXfer();
  endtask

  task automatic test_read_grant_delay();
    startXfer(1'b1, 25'h3, 4'b0011, 32'h0);
    bus.OPB_DBus = 32'hCAFE_F00D;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if ({bus.M_request, bus.M_select} !== 2'b10) begin
        miscompares++;
        $display("[TB] FAIL rd_grant_wait%0d: got %b expected %b", i, {bus.M_request, bus.M_select}, 2'b10);
      end
    end
    bus.OPB_MGrant = 1'b1;
    tick();
    bus.OPB_MGrant  = 1'b0;
    bus.OPB_xferAck = 1'b1;
    vectors++;
    if ({bus.M_select, bus.M_RNW, bus.M_BE, epb_data_oe_n} !== 7'b11_0011_1) begin
      miscompares++;
      $display("[TB] FAIL rd_xfer_ctrl: got %b expected %b", {bus.M_select, bus.M_RNW, bus.M_BE, epb_data_oe_n}, 7'b11_0011_1);
    end
    vectors++;
    if ({bus.M_ABus, bus.M_DBus} !== {ADDR_BASE | 32'hC, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL rd_xfer_bus: got %h/%h expected %h/%h", bus.M_ABus, bus.M_DBus, ADDR_BASE | 32'hC, 32'h0);
    end
    tick();
    bus.OPB_xferAck = 1'b0;
    vectors++;
    if ({epb_rdy, epb_data_oe_n, epb_data_o} !== {2'b10, 32'hCAFE_F00D}) begin
      miscompares++;
      $display("[TB] FAIL rd_done: got rdy=%b oe_n=%b data=%h expected rdy=1 oe_n=0 data=cafef00d", epb_rdy, epb_data_oe_n, epb_data_o);
    end
    tick();
    vectors++;
    if ({epb_rdy, epb_data_oe_n} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL rd_hold: got %b expected %b", {epb_rdy, epb_data_oe_n}, 2'b00);
    end
    epb_oe_n = 1'b1;
    #1;
    vectors++;
    if (epb_data_oe_n !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rd_oe_release: got %b expected %b", epb_data_oe_n, 1'b1);
    end
    epb_oe_n = 1'b0;
    #1;
    epb_cs_n = 1'b1;
    #1;
    vectors++;
    if (epb_data_oe_n !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rd_cs_release: got %b expected %b", epb_data_oe_n, 1'b1);
    end
    endXfer();
  endtask

  task automatic test_retry_recover();
    int selc = 0;
    int rdyc = 0;
    startXfer(1'b0, 25'h20, 4'b1000, 32'h1357_9BDF);
    bus.OPB_MGrant = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (epb_rdy) rdyc++;
      if (bus.M_select) begin
        selc++;
        bus.OPB_retry   = (selc < 4);
        bus.OPB_xferAck = (selc >= 4);
      end else begin
        bus.OPB_retry   = 1'b0;
        bus.OPB_xferAck = 1'b0;
      end
    end
    vectors++;
    if (selc !== 4 || rdyc !== 1) begin
      miscompares++;
      $display("[TB] FAIL retry_ok_counts: got sel=%0d rdy=%0d expected sel=4 rdy=1", selc, rdyc);
    end
    vectors++;
    if ({err_flag, err_code} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL retry_ok_err: got %b expected %b", {err_flag, err_code}, 3'b000);
    end
    vectors++;
    if (epb_data_o !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("[TB] FAIL write_keeps_rdata: got %h expected %h", epb_data_o, 32'hCAFE_F00D);
    end
    endXfer();
  endtask

  task automatic test_cs_glitch();
    int reqc = 0;
    int rdyc = 0;
    int selc = 0;
    startXfer(1'b0, 25'h1, 4'b0000, 32'h0000_00FF);
    tick();
    epb_cs_n = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.M_request !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL cs_rise_req: got %b expected %b", bus.M_request, 1'b1);
    end
    bus.OPB_MGrant  = 1'b1;
    bus.OPB_xferAck = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.M_select) selc++;
      if (epb_rdy) rdyc++;
    end
    vectors++;
    if (selc !== 1 || rdyc !== 1 || bus.M_request !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL cs_rise_complete: got sel=%0d rdy=%0d req=%b expected sel=1 rdy=1 req=0", selc, rdyc, bus.M_request);
    end
    startXfer(1'b0, 25'h2, 4'b0000, 32'h0);
    tick();
    tick();
    tick();
    vectors++;
    if (epb_rdy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL glitch_rdy: got %b expected %b", epb_rdy, 1'b1);
    end
    epb_cs_n = 1'b1;
    tick();
    epb_cs_n = 1'b0;
    rdyc = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.M_request) reqc++;
      if (epb_rdy) rdyc++;
    end
    vectors++;
    if (reqc !== 0 || rdyc !== 0) begin
      miscompares++;
      $display("[TB] FAIL glitch_no_restart: got req=%0d rdy=%0d expected 0/0", reqc, rdyc);
    end
    endXfer();
  endtask

  task automatic test_retry_exhausted();
    int selc = 0;
    int rdyc = 0;
    startXfer(1'b1, 25'h5, 4'b0000, 32'h0);
    bus.OPB_DBus   = 32'h1111_2222;
    bus.OPB_MGrant = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (epb_rdy) rdyc++;
      if (bus.M_select) selc++;
      bus.OPB_retry = bus.M_select;
    end
    vectors++;
    if (selc !== MAXR || rdyc !== 1) begin
      miscompares++;
      $display("[TB] FAIL retry_exh_counts: got sel=%0d rdy=%0d expected sel=4 rdy=1", selc, rdyc);
    end
    vectors++;
    if ({err_flag, err_code} !== 3'b111) begin
      miscompares++;
      $display("[TB] FAIL retry_exh_err: got %b expected %b", {err_flag, err_code}, 3'b111);
    end
    vectors++;
    if (epb_data_o !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("[TB] FAIL retry_exh_data: got %h expected %h", epb_data_o, 32'hFFFF_FFFF);
    end
    endXfer();
  endtask

  task automatic test_watchdog();
    int selc = 0;
    int rdyc = 0;
    int run = 0;
    int maxRun = 0;
    startXfer(1'b1, 25'h7, 4'b0000, 32'h0);
    bus.OPB_DBus   = 32'h0;
    bus.OPB_MGrant = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (epb_rdy) rdyc++;
      if (bus.M_select) begin
        selc++;
        run++;
        if (run > maxRun) maxRun = run;
      end else begin
        run = 0;
      end
    end
    vectors++;
    if (selc !== TOUT || maxRun !== TOUT || rdyc !== 1) begin
      miscompares++;
      $display("[TB] FAIL wdog_counts: got sel=%0d run=%0d rdy=%0d expected 64/64/1", selc, maxRun, rdyc);
    end
    vectors++;
    if ({err_flag, err_code, epb_data_o} !== {3'b110, 32'hFFFF_FFFF}) begin
      miscompares++;
      $display("[TB] FAIL wdog_err: got flag=%b code=%b data=%h expected 1/10/ffffffff", err_flag, err_code, epb_data_o);
    end
    endXfer();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vectors++;
    if ({err_flag, err_code} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL err_clr: got %b expected %b", {err_flag, err_code}, 3'b000);
    end
  endtask

  task automatic test_errack_vs_clear();
    bit found = 1'b0;
    startXfer(1'b0, 25'h9, 4'b0000, 32'hDEAD_BEEF);
    bus.OPB_MGrant = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (bus.M_select) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("[TB] FAIL errack_select_wait: got no select expected select within 10 cycles");
    end
    bus.OPB_errAck = 1'b1;
    bus.OPB_retry  = 1'b1;
    err_clr        = 1'b1;
    tick();
    idleBus();
    vectors++;
    if ({epb_rdy, err_flag, err_code} !== 4'b1101) begin
      miscompares++;
      $display("[TB] FAIL errack_wins: got %b expected %b", {epb_rdy, err_flag, err_code}, 4'b1101);
    end
    endXfer();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vectors++;
    if ({err_flag, err_code} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL errack_clr: got %b expected %b", {err_flag, err_code}, 3'b000);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int reqc = 0;
    int rdyc = 0;
    startXfer(1'b1, 25'h2, 4'b0000, 32'h0);
    bus.OPB_MGrant = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (bus.M_select) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("[TB] FAIL rstmid_select_wait: got no select expected select within 10 cycles");
    end
    OPB_Rst = 1'b1;
    #1;
    vectors++;
    if ({bus.M_request, bus.M_select, epb_rdy, epb_data_oe_n, err_flag} !== 5'b00010) begin
      miscompares++;
      $display("[TB] FAIL rstmid_ctrl: got %b expected %b", {bus.M_request, bus.M_select, epb_rdy, epb_data_oe_n, err_flag}, 5'b00010);
    end
    vectors++;
    if ({bus.M_ABus, epb_data_o} !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_bus: got abus=%h data=%h expected 0/0", bus.M_ABus, epb_data_o);
    end
    tick();
    OPB_Rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.M_request || bus.M_select) reqc++;
      if (epb_rdy) rdyc++;
    end
    vectors++;
    if (reqc !== 0 || rdyc !== 0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_no_start: got req=%0d rdy=%0d expected 0/0", reqc, rdyc);
    end
    epb_cs_n = 1'b1;
    tick();
    epb_cs_n = 1'b0;
    bus.OPB_MGrant = 1'b0;
    tick();
    vectors++;
    if ({bus.M_request, bus.M_select} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL rstmid_restart: got %b expected %b", {bus.M_request, bus.M_select}, 2'b10);
    end
    bus.OPB_MGrant = 1'b1;
    tick();
    bus.OPB_MGrant  = 1'b0;
    bus.OPB_xferAck = 1'b1;
    tick();
    vectors++;
    if (epb_rdy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_complete: got %b expected %b", epb_rdy, 1'b1);
    end
    endXfer();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_grant_delay();
    test_retry_recover();
    test_cs_glitch();
    test_retry_exhausted();
    test_watchdog();
    test_errack_vs_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
